multicycle_main_cu: RTL and testbench
=====================================

Name: multicycle_main_cu

Overview:
- Main control FSM for the multicycle RV32 subset datapath (lw, sw, R-type, beq).
- Decodes the 7-bit opcode and sequences fetch/decode/execute/memory/writeback.
- Drives the 2-bit ALU operation class that the ALU control decoder consumes, plus all datapath mux/enable strobes.
- Sits between the instruction register and the datapath; memory accesses stall on a ready handshake.

Parameters:
- OP_LW, 7'b0000011, load word opcode
- OP_SW, 7'b0100011, store word opcode
- OP_R, 7'b0110011, R-type opcode
- OP_BEQ, 7'b1100011, branch-equal opcode

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- opcode  input  7  instr[6:0] from instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completed current access this cycle
- pc_en  output  1  PC load enable = pc_write | (branch & zero)
- adr_src  output  1  0: address from PC, 1: address from ALU result register
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register load
- result_src  output  2  00 ALUOut, 01 memory data, 10 ALU result
- alu_src_a  output  2  00 PC, 01 old PC, 10 rs1 data
- alu_src_b  output  2  00 rs2 data, 01 immediate, 10 constant 4
- alu_op  output  2  00 add (addr/PC), 01 subtract (beq), 10 decode func3/func7
- reg_write  output  1  register file write enable
- illegal  output  1  one-cycle pulse, unsupported opcode seen in DECODE
- state  output  4  current state encoding (debug)

Behaviour:
- States (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, BEQ=8.
- Registered state; all outputs are Moore decodes of state plus mem_ready/zero gating. Unlisted outputs are 0 in every state.
- Reset: state=FETCH on the clock edge with rst=1. Reset wins over every transition, including mid-instruction; no partial writeback completes.
- FETCH:
  - adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=01, alu_src_b=01, alu_op=00 (branch target).
  - Next state: lw/sw→MEMADR, R→EXECR, beq→BEQ.
  - Any other opcode: illegal=1 this cycle, next state FETCH.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. lw→MEMREAD, sw→MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Holds until mem_ready=1, then MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE:
  - adr_src=1, result_src=00, mem_write=1 every cycle in state.
  - Holds until mem_ready=1, then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BEQ:
  - alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, so pc_en=zero.
  - Next state FETCH.
- opcode is sampled every cycle. It must remain stable from DECODE to instruction end (the IR is only written in FETCH).
- Cycle counts with mem_ready tied to 1: lw 5, sw 4, R 4, beq 3, illegal 2.
- pc_en is never asserted outside FETCH/BEQ. reg_write and mem_write are never high in the same cycle.
- alu_op=11 is never driven.

Test Plan:
- rst=1 for 2 cycles, then mem_ready=1, opcode=0x33 → states 0,1,6,7,0. alu_op=10 in EXECR, reg_write=1 only in ALUWB, pc_en=1 only in FETCH.
- opcode=0x03, mem_ready=1 → states 0,1,2,3,4,0. result_src=01 with reg_write=1 in MEMWB; adr_src=1 in MEMREAD.
- opcode=0x23, mem_ready low for 3 cycles in MEMWRITE → mem_write=1 for 4 cycles, stays state 5, then FETCH. reg_write never set.
- opcode=0x63 with zero=1 → pc_en=1 in BEQ, alu_op=01. Repeat with zero=0 → pc_en=0 in BEQ.
- mem_ready=0 in FETCH for 5 cycles → ir_write=pc_en=0, state=0 throughout. First cycle with mem_ready=1 pulses both, next state 1.
- opcode=0x13 (unsupported) → illegal=1 for one cycle in DECODE, then FETCH. Separately, assert rst during MEMWB → next state 0, no further reg_write.

Source files
------------

// File: rtl/multicycle_main_cu_if.sv
// -----------------------------------------------------------------------------
// multicycle_main_cu_if
// Bundle between the multicycle main control unit and the datapath.
//   opcode     : instr[6:0] from the instruction register
//   zero       : ALU zero flag
//   mem_ready  : memory finished the current access this cycle
//   pc_en      : PC load enable
//   adr_src    : memory address select (0 PC, 1 ALU result register)
//   mem_write  : memory write strobe
//   ir_write   : instruction register load
//   result_src : result mux select (00 ALUOut, 01 mem data, 10 ALU result)
//   alu_src_a  : ALU A select (00 PC, 01 old PC, 10 rs1)
//   alu_src_b  : ALU B select (00 rs2, 01 imm, 10 const 4)
//   alu_op     : ALU operation class (00 add, 01 sub, 10 decode funct)
//   reg_write  : register file write enable
//   illegal    : one-cycle pulse, unsupported opcode in DECODE
//   state      : current FSM state (debug)
// master = control unit side, slave = datapath side.
// -----------------------------------------------------------------------------
interface multicycle_main_cu_if;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_en;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic       reg_write;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  opcode, zero, mem_ready,
      output pc_en, adr_src, mem_write, ir_write, result_src,
             alu_src_a, alu_src_b, alu_op, reg_write, illegal, state
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_en, adr_src, mem_write, ir_write, result_src,
             alu_src_a, alu_src_b, alu_op, reg_write, illegal, state
   );
endinterface

// File: rtl/multicycle_main_cu.sv
// -----------------------------------------------------------------------------
// multicycle_main_cu
// Main control FSM for the multicycle RV32 subset datapath (lw, sw, R, beq).
// Sequences fetch/decode/execute/memory/writeback and drives every datapath
// mux select and enable. Memory states stall until mem_ready is seen.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset (returns the FSM to FETCH)
//   cu  : control bundle (multicycle_main_cu_if.master), see interface header
// -----------------------------------------------------------------------------
module multicycle_main_cu #(
   parameter logic [6:0] OP_LW  = 7'b0000011,
   parameter logic [6:0] OP_SW  = 7'b0100011,
   parameter logic [6:0] OP_R   = 7'b0110011,
   parameter logic [6:0] OP_BEQ = 7'b1100011
) (
   input logic                  clk,
   input logic                  rst,
   multicycle_main_cu_if.master cu
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_BEQ      = 4'd8
   } state_t;

   state_t     state_q, state_d;

   logic       pc_write;
   logic       branch;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic       reg_write;
   logic       illegal;

   // Next-state and Moore output decode.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned; otherwise synthesis infers a latch.
      state_d    = state_q;
      pc_write   = 1'b0;
      branch     = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      reg_write  = 1'b0;
      illegal    = 1'b0;

      unique case (state_q)
         S_FETCH: begin
            // PC + 4 is computed and written back as the fetch completes.
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = cu.mem_ready;
            pc_write   = cu.mem_ready;
            if (cu.mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            // Precompute the branch target (old PC + imm) into ALUOut.
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            if (cu.opcode == OP_LW || cu.opcode == OP_SW) state_d = S_MEMADR;
            else if (cu.opcode == OP_R)                   state_d = S_EXECR;
            else if (cu.opcode == OP_BEQ)                 state_d = S_BEQ;
            else begin
               illegal = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            // Only lw and sw reach this state, so anything but lw is a store.
            state_d   = (cu.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            if (cu.mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
            if (cu.mem_ready) state_d = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BEQ: begin
            // ALUOut holds the branch target; zero decides whether it loads.
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            branch    = 1'b1;
            state_d   = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   assign cu.pc_en      = pc_write | (branch & cu.zero);
   assign cu.adr_src    = adr_src;
   assign cu.mem_write  = mem_write;
   assign cu.ir_write   = ir_write;
   assign cu.result_src = result_src;
   assign cu.alu_src_a  = alu_src_a;
   assign cu.alu_src_b  = alu_src_b;
   assign cu.alu_op     = alu_op;
   assign cu.reg_write  = reg_write;
   assign cu.illegal    = illegal;
   assign cu.state      = state_q;

endmodule

// File: tb/tb_multicycle_main_cu.sv
// -----------------------------------------------------------------------------
// tb_multicycle_main_cu
// Scoreboard bench for multicycle_main_cu. The stimulus process drives one
// cycle at a time, asks an instruction-level reference model what the DUT
// should present in that cycle, and queues it. A monitor on the falling edge
// pops and compares every output field.
// -----------------------------------------------------------------------------
module tb_multicycle_main_cu;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum int { K_LW, K_SW, K_R, K_BEQ, K_ILL } kind_t;

   typedef struct packed {
      logic [3:0] state;
      logic       pc_en;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       illegal;
   } exp_t;

   logic clk;
   logic rst;

   multicycle_main_cu_if bus ();

   multicycle_main_cu dut (
      .clk (clk),
      .rst (rst),
      .cu  (bus)
   );

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];

   // Reference model: position inside the instruction's state walk.
   int   m_idx   = 0;
   bit   m_valid = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic kind_t kind_of(input logic [6:0] op);
      case (op)
         OP_LW:   return K_LW;
         OP_SW:   return K_SW;
         OP_R:    return K_R;
         OP_BEQ:  return K_BEQ;
         default: return K_ILL;
      endcase
   endfunction

   // State walk of each instruction class.
   function automatic int seq_len(input kind_t k);
      case (k)
         K_LW:    return 5;
         K_SW:    return 4;
         K_R:     return 4;
         K_BEQ:   return 3;
         default: return 2;
      endcase
   endfunction

   function automatic int seq_at(input kind_t k, input int idx);
      int lw_s[5]  = '{0, 1, 2, 3, 4};
      int sw_s[4]  = '{0, 1, 2, 5};
      int r_s[4]   = '{0, 1, 6, 7};
      int beq_s[3] = '{0, 1, 8};
      case (k)
         K_LW:    return lw_s[idx];
         K_SW:    return sw_s[idx];
         K_R:     return r_s[idx];
         K_BEQ:   return beq_s[idx];
         default: return idx;
      endcase
   endfunction

   // Output table from the state description.
   function automatic exp_t expect_for(input int st, input kind_t k,
                                       input logic z, input logic mr);
      exp_t e;
      e       = '0;
      e.state = 4'(st);
      case (st)
         0: begin
            e.alu_src_b  = 2'b10;
            e.result_src = 2'b10;
            e.ir_write   = mr;
            e.pc_en      = mr;
         end
         1: begin
            e.alu_src_a = 2'b01;
            e.alu_src_b = 2'b01;
            e.illegal   = (k == K_ILL);
         end
         2: begin
            e.alu_src_a = 2'b10;
            e.alu_src_b = 2'b01;
         end
         3: e.adr_src = 1'b1;
         4: begin
            e.result_src = 2'b01;
            e.reg_write  = 1'b1;
         end
         5: begin
            e.adr_src   = 1'b1;
            e.mem_write = 1'b1;
         end
         6: begin
            e.alu_src_a = 2'b10;
            e.alu_op    = 2'b10;
         end
         7: e.reg_write = 1'b1;
         8: begin
            e.alu_src_a = 2'b10;
            e.alu_op    = 2'b01;
            e.pc_en     = z;
         end
         default: e = '0;
      endcase
      return e;
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // One clock of stimulus plus the matching model step.
   task automatic cycle(input logic r, input logic [6:0] op, input logic z, input logic mr);
      kind_t k;
      int    s;
      @(posedge clk);
      #1;
      rst           = r;
      bus.opcode    = op;
      bus.zero      = z;
      bus.mem_ready = mr;
      k = kind_of(op);
      if (m_valid) begin
         s = seq_at(k, m_idx);
         exp_q.push_back(expect_for(s, k, z, mr));
      end
      if (r) begin
         m_idx   = 0;
         m_valid = 1;
      end else if (m_valid) begin
         s = seq_at(k, m_idx);
         // FETCH, MEMREAD and MEMWRITE wait for the memory.
         if (!((s == 0 || s == 3 || s == 5) && !mr))
            m_idx = (m_idx == seq_len(k) - 1) ? 0 : m_idx + 1;
      end
   endtask

   task automatic run(input logic [6:0] op, input logic z, input logic mr, input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, op, z, mr);
   endtask

   // Monitor: compares whatever the DUT presents against the queued model.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state",      bus.state,              e.state);
            check("pc_en",      {3'b0, bus.pc_en},      {3'b0, e.pc_en});
            check("adr_src",    {3'b0, bus.adr_src},    {3'b0, e.adr_src});
            check("mem_write",  {3'b0, bus.mem_write},  {3'b0, e.mem_write});
            check("ir_write",   {3'b0, bus.ir_write},   {3'b0, e.ir_write});
            check("result_src", {2'b0, bus.result_src}, {2'b0, e.result_src});
            check("alu_src_a",  {2'b0, bus.alu_src_a},  {2'b0, e.alu_src_a});
            check("alu_src_b",  {2'b0, bus.alu_src_b},  {2'b0, e.alu_src_b});
            check("alu_op",     {2'b0, bus.alu_op},     {2'b0, e.alu_op});
            check("reg_write",  {3'b0, bus.reg_write},  {3'b0, e.reg_write});
            check("illegal",    {3'b0, bus.illegal},    {3'b0, e.illegal});
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic [6:0] op;
      int         pick;
      rst           = 1'b1;
      bus.opcode    = OP_R;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b1;

      // Reset for two cycles.
      cycle(1'b1, OP_R, 1'b0, 1'b1);
      cycle(1'b1, OP_R, 1'b0, 1'b1);

      // R-type: 0,1,6,7.
      run(OP_R, 1'b0, 1'b1, 4);
      // lw: 0,1,2,3,4.
      run(OP_LW, 1'b0, 1'b1, 5);
      // sw with memory stalled three cycles in MEMWRITE.
      run(OP_SW, 1'b0, 1'b1, 3);
      run(OP_SW, 1'b0, 1'b0, 3);
      run(OP_SW, 1'b0, 1'b1, 1);
      // beq taken, then not taken.
      run(OP_BEQ, 1'b1, 1'b1, 3);
      run(OP_BEQ, 1'b0, 1'b1, 3);
      // Fetch stalled five cycles, then an R-type.
      run(OP_R, 1'b0, 1'b0, 5);
      run(OP_R, 1'b0, 1'b1, 4);
      // Unsupported opcode.
      run(7'h13, 1'b0, 1'b1, 2);
      // lw interrupted by reset while in MEMWB, then an R-type.
      run(OP_LW, 1'b0, 1'b1, 4);
      cycle(1'b1, OP_LW, 1'b0, 1'b1);
      run(OP_R, 1'b0, 1'b1, 4);

      // Randomised traffic: opcode only changes while in FETCH.
      op = OP_R;
      for (int i = 0; i < 800; i++) begin
         if (m_idx == 0 && $urandom_range(0, 1) == 1) begin
            pick = int'($urandom_range(0, 9));
            case (pick)
               0, 1:    op = OP_LW;
               2, 3:    op = OP_SW;
               4, 5:    op = OP_R;
               6, 7:    op = OP_BEQ;
               8:       op = 7'($urandom_range(0, 127));
               default: op = op;
            endcase
         end
         cycle($urandom_range(0, 49) == 0, op, 1'($urandom_range(0, 1)),
               $urandom_range(0, 3) != 0);
      end

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drained: %0d entries left, expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
